tile_config_mem_seq: RTL and testbench
======================================

# tile_config_mem_seq

Clocked, double-buffered configuration memory for a FABulous tile: frames arriving on FrameData/FrameStrobe are captured into a shadow bank, tracked per frame, and copied atomically into the active bank on a commit request. ConfigBits/ConfigBits_N drive the tile's switch matrix and BELs from the active bank only, so partial reconfiguration never exposes half-written state. Any frame of either bank can be read back. This block is the sequential successor to the latch-based per-tile config memory and keeps the emulation override.

## Interface
- MaxFramesPerCol, 32, number of frame strobe lines
- FrameBitsPerRow, 32, frame data width
- NoConfigBits, 0, config bits used by the tile; FramesUsed = ceil(NoConfigBits/FrameBitsPerRow), must be ≤ MaxFramesPerCol
- EMULATION_ENABLE, 0, 1 = outputs forced to EMULATION_CONFIG
- EMULATION_CONFIG, 0, NoConfigBits-wide constant used in emulation

- CLK  in  1  config clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- FrameData  in  FrameBitsPerRow  frame payload
- FrameStrobe  in  MaxFramesPerCol  per-frame write enable, sampled each edge
- commit  in  1  request shadow→active copy
- rb_req  in  1  readback request
- rb_sel  in  1  0 = shadow bank, 1 = active bank
- rb_frame  in  clog2(MaxFramesPerCol)  frame index to read
- ConfigBits  out  NoConfigBits  active bank
- ConfigBits_N  out  NoConfigBits  bitwise inverse of ConfigBits
- rb_data  out  FrameBitsPerRow  readback payload
- rb_valid  out  1  rb_data valid strobe
- commit_done  out  1  one-cycle pulse, copy performed
- commit_err  out  1  one-cycle pulse, commit rejected
- load_state  out  2  0 EMPTY, 1 PARTIAL, 2 COMPLETE

## Operation
- Bit mapping: config bit i ↔ frame i/FrameBitsPerRow, bit i%FrameBitsPerRow; unused upper bits of the last frame are not stored.
- Write: at each edge, for every f < FramesUsed with FrameStrobe[f]=1, shadow frame f ← FrameData and written[f] ← 1. Several strobes in one cycle write the same data to all selected frames. Strobes for f ≥ FramesUsed are ignored.
- Load FSM from written mask: EMPTY (mask 0), PARTIAL (nonzero, not full), COMPLETE (all FramesUsed bits set). Rewriting a written frame is allowed and keeps state.
- Commit in COMPLETE: active ← shadow, mask cleared → EMPTY, commit_done pulses. Commit in EMPTY/PARTIAL: nothing changes, commit_err pulses.
- Write and commit in the same cycle: commit uses shadow contents and mask before the edge; the same-cycle write lands in shadow and leaves mask = the bits strobed that cycle (state PARTIAL or COMPLETE accordingly).
- Readback: rb_req samples rb_sel/rb_frame; rb_data = selected frame, unused bits 0; rb_frame ≥ FramesUsed returns all zeros. rb_req in a cycle where the addressed frame is also being written or committed returns pre-edge contents.
- Emulation (EMULATION_ENABLE=1): ConfigBits = ConfigBits_N = EMULATION_CONFIG constantly; writes and commit update nothing; commit always pulses commit_done; readback returns zeros; load_state stays EMPTY.
- NoConfigBits=0: no storage; commit always pulses commit_done; readback returns zeros.

## Timing
- Reset (async assert, any time including mid-load or mid-commit): shadow and active banks 0, mask 0, ConfigBits 0, ConfigBits_N all ones, rb_data 0, rb_valid 0, commit_done 0, commit_err 0, load_state EMPTY.
- Write latency: strobe at edge N → shadow/load_state updated after edge N.
- Commit latency: commit sampled at edge N → ConfigBits/ConfigBits_N change after edge N; commit_done or commit_err high for the cycle after edge N only.
- Readback latency: rb_req at edge N → rb_valid high and rb_data held for one cycle after edge N; rb_data holds last value when rb_valid=0. Back-to-back requests every cycle are supported.
- commit held high for consecutive cycles is evaluated independently each edge (second cycle normally yields commit_err since mask is cleared).

## Test plan
- Reset then NoConfigBits=40, FrameBitsPerRow=32: ConfigBits=0, ConfigBits_N=0xFF_FFFF_FFFF, load_state=0.
- Write frame0=0xDEADBEEF, commit → commit_err pulse, ConfigBits unchanged, load_state=1; write frame1=0x000000A5, commit → commit_done, ConfigBits=0xA5_DEADBEEF, load_state=0.
- Strobe frames 0,1 together with 0x12345678 → load_state=2; readback rb_sel=0 frame1 → rb_data=0x00000078 next cycle.
- Commit and write frame0=0x1 in the same cycle after full load → active gets old shadow, load_state=1, readback active frame0 shows old data.
- Assert reset mid-load (one frame written) → all outputs at reset values; readback frame 5 (beyond FramesUsed) → 0.
- EMULATION_ENABLE=1, EMULATION_CONFIG=0x3C: writes ignored, ConfigBits=ConfigBits_N=0x3C, commit → commit_done.

Source files
------------

// File: rtl/tile_config_mem_seq.sv
// tile_config_mem_seq: double-buffered tile configuration memory with frame tracking,
// atomic shadow-to-active commit, per-frame readback and emulation override.
module tile_config_mem_seq #(
   parameter int MaxFramesPerCol = 32,
   parameter int FrameBitsPerRow = 32,
   parameter int NoConfigBits = 0,
   parameter bit EMULATION_ENABLE = 1'b0,
   parameter logic [((NoConfigBits > 0) ? NoConfigBits : 1)-1:0] EMULATION_CONFIG = '0
) (
   input  logic                                                             CLK,
   input  logic                                                             reset,
   input  logic [FrameBitsPerRow-1:0]                                       FrameData,
   input  logic [MaxFramesPerCol-1:0]                                       FrameStrobe,
   input  logic                                                             commit,
   input  logic                                                             rb_req,
   input  logic                                                             rb_sel,
   input  logic [((MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1)-1:0] rb_frame,
   output logic [((NoConfigBits > 0) ? NoConfigBits : 1)-1:0]               ConfigBits,
   output logic [((NoConfigBits > 0) ? NoConfigBits : 1)-1:0]               ConfigBits_N,
   output logic [FrameBitsPerRow-1:0]                                       rb_data,
   output logic                                                             rb_valid,
   output logic                                                             commit_done,
   output logic                                                             commit_err,
   output logic [1:0]                                                       load_state
);
   localparam int CW = (NoConfigBits > 0) ? NoConfigBits : 1;
   localparam int AW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
   localparam int FU = (NoConfigBits + FrameBitsPerRow - 1) / FrameBitsPerRow;
   localparam int FUS = (FU > 0) ? FU : 1;
   localparam bit STORE = (NoConfigBits > 0) && !EMULATION_ENABLE;

   typedef logic [FrameBitsPerRow-1:0] frame_t;
   typedef enum logic [1:0] {EMPTY = 2'd0, PARTIAL = 2'd1, COMPLETE = 2'd2} load_t;

   frame_t shadow_q [FUS];
   frame_t shadow_d [FUS];
   frame_t active_q [FUS];
   frame_t active_d [FUS];
   frame_t vmask [FUS];
   frame_t rb_data_q, rb_data_d, rb_pick;
   logic [FUS-1:0] written_q, written_d, strb;
   logic rb_valid_q, done_q, err_q, commit_ok, full;
   logic [CW-1:0] cfg;
   load_t ls;
   logic unused_ok;

   // Bits beyond NoConfigBits in the last frame are forced to zero and never stored.
   for (genvar f = 0; f < FUS; f++) begin : g_mask
      for (genvar b = 0; b < FrameBitsPerRow; b++) begin : g_bit
         assign vmask[f][b] = (f * FrameBitsPerRow + b) < NoConfigBits;
      end
   end

   for (genvar i = 0; i < CW; i++) begin : g_cfg
      assign cfg[i] = active_q[i / FrameBitsPerRow][i % FrameBitsPerRow];
   end

   assign full = written_q == '1;
   assign commit_ok = commit && (!STORE || full);
   assign ls = (written_q == '0) ? EMPTY : (full ? COMPLETE : PARTIAL);
   assign unused_ok = ^FrameStrobe;

   always_comb begin
      strb = '0;
      rb_pick = '0;
      for (int f = 0; f < FUS; f++) begin
         strb[f] = STORE && FrameStrobe[f];
         shadow_d[f] = strb[f] ? (FrameData & vmask[f]) : shadow_q[f];
         active_d[f] = (STORE && commit_ok) ? shadow_q[f] : active_q[f];
         if (STORE && rb_frame == AW'(f)) rb_pick = rb_sel ? active_q[f] : shadow_q[f];
      end
      written_d = ((STORE && commit_ok) ? '0 : written_q) | strb;
      rb_data_d = rb_req ? rb_pick : rb_data_q;
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         for (int f = 0; f < FUS; f++) begin
            shadow_q[f] <= '0;
            active_q[f] <= '0;
         end
         written_q <= '0;
         rb_data_q <= '0;
         rb_valid_q <= 1'b0;
         done_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         for (int f = 0; f < FUS; f++) begin
            shadow_q[f] <= shadow_d[f];
            active_q[f] <= active_d[f];
         end
         written_q <= written_d;
         rb_data_q <= rb_data_d;
         rb_valid_q <= rb_req;
         done_q <= commit_ok;
         err_q <= commit && !commit_ok;
      end
   end

   assign ConfigBits = EMULATION_ENABLE ? EMULATION_CONFIG : cfg;
   assign ConfigBits_N = EMULATION_ENABLE ? EMULATION_CONFIG : ~cfg;
   assign rb_data = rb_data_q;
   assign rb_valid = rb_valid_q;
   assign commit_done = done_q;
   assign commit_err = err_q;
   assign load_state = ls;
endmodule

// File: tb/tb_tile_config_mem_seq.sv
// tb_tile_config_mem_seq: directed checks of load tracking, commit, readback, reset and emulation.
module tb_tile_config_mem_seq;
   logic CLK = 1'b0;
   logic reset = 1'b1;
   logic [31:0] FrameData = '0;
   logic [31:0] FrameStrobe = '0;
   logic commit = 1'b0, rb_req = 1'b0, rb_sel = 1'b0;
   logic [4:0] rb_frame = '0;
   logic [39:0] cfg, cfg_n;
   logic [31:0] rbd;
   logic rbv, done, err;
   logic [1:0] ls;
   logic [7:0] cfg_e, cfg_n_e;
   logic [31:0] rbd_e;
   logic rbv_e, done_e, err_e;
   logic [1:0] ls_e;
   int total = 0, bad = 0;

   always #5 CLK = ~CLK;

   tile_config_mem_seq #(.MaxFramesPerCol(32), .FrameBitsPerRow(32), .NoConfigBits(40)) dut (
      .CLK(CLK), .reset(reset), .FrameData(FrameData), .FrameStrobe(FrameStrobe), .commit(commit),
      .rb_req(rb_req), .rb_sel(rb_sel), .rb_frame(rb_frame), .ConfigBits(cfg), .ConfigBits_N(cfg_n),
      .rb_data(rbd), .rb_valid(rbv), .commit_done(done), .commit_err(err), .load_state(ls));

   tile_config_mem_seq #(.MaxFramesPerCol(32), .FrameBitsPerRow(32), .NoConfigBits(8),
                         .EMULATION_ENABLE(1'b1), .EMULATION_CONFIG(8'h3C)) emu (
      .CLK(CLK), .reset(reset), .FrameData(FrameData), .FrameStrobe(FrameStrobe), .commit(commit),
      .rb_req(rb_req), .rb_sel(rb_sel), .rb_frame(rb_frame), .ConfigBits(cfg_e), .ConfigBits_N(cfg_n_e),
      .rb_data(rbd_e), .rb_valid(rbv_e), .commit_done(done_e), .commit_err(err_e), .load_state(ls_e));

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      #1;
      total++; if (cfg !== 40'h0) begin bad++; $display("FAIL reset_cfg got=%h want=0", cfg); end
      total++; if (cfg_n !== 40'hFF_FFFF_FFFF) begin bad++; $display("FAIL reset_cfg_n got=%h want=ffffffffff", cfg_n); end
      total++; if (ls !== 2'd0) begin bad++; $display("FAIL reset_ls got=%0d want=0", ls); end
      total++; if ({rbv, done, err} !== 3'b000 || rbd !== 32'h0) begin bad++; $display("FAIL reset_flags got=%b/%h want=000/0", {rbv, done, err}, rbd); end
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_partial_commit();
      FrameStrobe = 32'h1; FrameData = 32'hDEADBEEF; tick();
      FrameStrobe = 32'h0; commit = 1'b1; tick();
      total++; if ({done, err} !== 2'b01) begin bad++; $display("FAIL partial_commit_err got=%b want=01", {done, err}); end
      total++; if (cfg !== 40'h0) begin bad++; $display("FAIL partial_cfg got=%h want=0", cfg); end
      total++; if (ls !== 2'd1) begin bad++; $display("FAIL partial_ls got=%0d want=1", ls); end
      commit = 1'b0; tick();
      total++; if (err !== 1'b0) begin bad++; $display("FAIL err_one_cycle got=%b want=0", err); end
      FrameStrobe = 32'h2; FrameData = 32'h000000A5; tick();
      total++; if (ls !== 2'd2) begin bad++; $display("FAIL full_ls got=%0d want=2", ls); end
      FrameStrobe = 32'h0; commit = 1'b1; tick();
      total++; if ({done, err} !== 2'b10) begin bad++; $display("FAIL commit_done got=%b want=10", {done, err}); end
      total++; if (cfg !== 40'hA5_DEADBEEF) begin bad++; $display("FAIL commit_cfg got=%h want=a5deadbeef", cfg); end
      total++; if (cfg_n !== 40'h5A_21524110) begin bad++; $display("FAIL commit_cfg_n got=%h want=5a21524110", cfg_n); end
      total++; if (ls !== 2'd0) begin bad++; $display("FAIL commit_ls got=%0d want=0", ls); end
      tick();
      total++; if ({done, err} !== 2'b01) begin bad++; $display("FAIL held_commit got=%b want=01", {done, err}); end
      commit = 1'b0;
   endtask

   task automatic test_multi_strobe();
      FrameStrobe = 32'h3; FrameData = 32'h12345678; tick();
      FrameStrobe = 32'h0;
      total++; if (ls !== 2'd2) begin bad++; $display("FAIL multi_ls got=%0d want=2", ls); end
      rb_req = 1'b1; rb_sel = 1'b0; rb_frame = 5'd1; tick();
      total++; if (rbv !== 1'b1 || rbd !== 32'h00000078) begin bad++; $display("FAIL rb_shadow1 got=%b/%h want=1/00000078", rbv, rbd); end
      rb_req = 1'b0; tick();
      total++; if (rbv !== 1'b0 || rbd !== 32'h00000078) begin bad++; $display("FAIL rb_hold got=%b/%h want=0/00000078", rbv, rbd); end
   endtask

   task automatic test_back_to_back();
      rb_req = 1'b1; rb_sel = 1'b0; rb_frame = 5'd0; tick();
      total++; if (rbv !== 1'b1 || rbd !== 32'h12345678) begin bad++; $display("FAIL b2b_0 got=%b/%h want=1/12345678", rbv, rbd); end
      rb_sel = 1'b1; rb_frame = 5'd0; tick();
      total++; if (rbv !== 1'b1 || rbd !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_1 got=%b/%h want=1/deadbeef", rbv, rbd); end
      rb_frame = 5'd1; tick();
      total++; if (rbv !== 1'b1 || rbd !== 32'h000000A5) begin bad++; $display("FAIL b2b_2 got=%b/%h want=1/000000a5", rbv, rbd); end
      rb_req = 1'b0;
   endtask

   task automatic test_commit_write();
      commit = 1'b1; FrameStrobe = 32'h1; FrameData = 32'h00000001;
      rb_req = 1'b1; rb_sel = 1'b1; rb_frame = 5'd0; tick();
      commit = 1'b0; FrameStrobe = 32'h0;
      total++; if (done !== 1'b1) begin bad++; $display("FAIL cw_done got=%b want=1", done); end
      total++; if (cfg !== 40'h78_12345678) begin bad++; $display("FAIL cw_cfg got=%h want=7812345678", cfg); end
      total++; if (ls !== 2'd1) begin bad++; $display("FAIL cw_ls got=%0d want=1", ls); end
      total++; if (rbd !== 32'hDEADBEEF) begin bad++; $display("FAIL cw_rb_pre got=%h want=deadbeef", rbd); end
      tick();
      total++; if (rbd !== 32'h12345678) begin bad++; $display("FAIL cw_rb_active got=%h want=12345678", rbd); end
      rb_sel = 1'b0; tick();
      total++; if (rbd !== 32'h00000001) begin bad++; $display("FAIL cw_rb_shadow got=%h want=00000001", rbd); end
      rb_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      FrameStrobe = 32'h2; FrameData = 32'hFFFFFFFF; tick();
      FrameStrobe = 32'h0; rb_req = 1'b1; rb_sel = 1'b0; rb_frame = 5'd1; tick();
      total++; if (rbd !== 32'h000000FF) begin bad++; $display("FAIL last_frame_mask got=%h want=000000ff", rbd); end
      rb_req = 1'b0; #2; reset = 1'b1; #1;
      total++; if (cfg !== 40'h0 || cfg_n !== 40'hFF_FFFF_FFFF) begin bad++; $display("FAIL async_cfg got=%h/%h want=0/ffffffffff", cfg, cfg_n); end
      total++; if (ls !== 2'd0 || rbd !== 32'h0 || rbv !== 1'b0) begin bad++; $display("FAIL async_state got=%0d/%h/%b want=0/0/0", ls, rbd, rbv); end
      tick();
      reset = 1'b0;
      rb_req = 1'b1; rb_frame = 5'd5; FrameStrobe = 32'h20; FrameData = 32'hAAAA5555; tick();
      total++; if (rbv !== 1'b1 || rbd !== 32'h0) begin bad++; $display("FAIL rb_beyond got=%b/%h want=1/0", rbv, rbd); end
      total++; if (ls !== 2'd0) begin bad++; $display("FAIL strobe_beyond_ls got=%0d want=0", ls); end
      rb_sel = 1'b1; rb_frame = 5'd1; FrameStrobe = 32'h0; tick();
      total++; if (rbd !== 32'h0) begin bad++; $display("FAIL rb_active_cleared got=%h want=0", rbd); end
      rb_req = 1'b0;
   endtask

   task automatic test_emulation();
      FrameStrobe = 32'h1; FrameData = 32'hFF; tick();
      FrameStrobe = 32'h0;
      total++; if (cfg_e !== 8'h3C || cfg_n_e !== 8'h3C) begin bad++; $display("FAIL emu_cfg got=%h/%h want=3c/3c", cfg_e, cfg_n_e); end
      total++; if (ls_e !== 2'd0) begin bad++; $display("FAIL emu_ls got=%0d want=0", ls_e); end
      commit = 1'b1; rb_req = 1'b1; rb_sel = 1'b0; rb_frame = 5'd0; tick();
      commit = 1'b0; rb_req = 1'b0;
      total++; if ({done_e, err_e} !== 2'b10) begin bad++; $display("FAIL emu_commit got=%b want=10", {done_e, err_e}); end
      total++; if (rbv_e !== 1'b1 || rbd_e !== 32'h0) begin bad++; $display("FAIL emu_rb got=%b/%h want=1/0", rbv_e, rbd_e); end
      total++; if (cfg_e !== 8'h3C) begin bad++; $display("FAIL emu_cfg_after got=%h want=3c", cfg_e); end
   endtask

   initial begin
      test_reset();
      test_partial_commit();
      test_multi_strobe();
      test_back_to_back();
      test_commit_write();
      test_reset_mid();
      test_emulation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
